// File: rtl/exu_oitf_if.sv
// Dispatch / retire / hazard-check bundle for the outstanding-instruction track FIFO.
// The master side is the dispatch+writeback pair, the slave side is the OITF itself.
interface exu_oitf_if #(
  parameter int DEPTH   = 2,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int RFIDX_W = 5,
  parameter int PC_W    = 32
);
  logic               dis_ena;
  logic               dis_rdwen;
  logic [RFIDX_W-1:0] dis_rdidx;
  logic [PC_W-1:0]    dis_pc;
  logic [PTR_W-1:0]   dis_ptr;
  logic               oitf_full;
  logic               oitf_empty;

  logic               ret_ena;
  logic [PTR_W-1:0]   ret_ptr;
  logic               ret_rdwen;
  logic [RFIDX_W-1:0] ret_rdidx;
  logic [PC_W-1:0]    ret_pc;

  logic               chk_rs1en;
  logic [RFIDX_W-1:0] chk_rs1idx;
  logic               chk_rs2en;
  logic [RFIDX_W-1:0] chk_rs2idx;
  logic               chk_rdwen;
  logic [RFIDX_W-1:0] chk_rdidx;
  logic               oitf_dep;

  modport master (
    output dis_ena, dis_rdwen, dis_rdidx, dis_pc, ret_ena,
           chk_rs1en, chk_rs1idx, chk_rs2en, chk_rs2idx, chk_rdwen, chk_rdidx,
    input  dis_ptr, oitf_full, oitf_empty, ret_ptr, ret_rdwen, ret_rdidx, ret_pc, oitf_dep
  );

  modport slave (
    input  dis_ena, dis_rdwen, dis_rdidx, dis_pc, ret_ena,
           chk_rs1en, chk_rs1idx, chk_rs2en, chk_rs2idx, chk_rdwen, chk_rdidx,
    output dis_ptr, oitf_full, oitf_empty, ret_ptr, ret_rdwen, ret_rdidx, ret_pc, oitf_dep
  );
endinterface

// File: rtl/exu_oitf.sv
// Outstanding-instruction track FIFO: allocates long-pipe instructions at dispatch,
// retires them oldest-first at writeback and flags RAW/WAW hazards for dispatch.
module exu_oitf #(
  parameter int DEPTH   = 2,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int RFIDX_W = 5,
  parameter int PC_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  exu_oitf_if.slave   oitf
);

  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;
  logic [DEPTH-1:0]   r_vld;
  logic [DEPTH-1:0]   r_rdwen;
  logic [RFIDX_W-1:0] r_rdidx [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];

  logic [PTR_W-1:0]   w_wr_idx;
  logic [PTR_W-1:0]   w_rd_idx;
  logic               w_empty;
  logic               w_full;
  logic               w_alloc;
  logic               w_retire;
  logic               w_dep;

  // The extra MSB on each pointer is the wrap flag that tells full from empty.
  assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
  assign w_rd_idx = r_rd_ptr[PTR_W-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
  assign w_alloc  = oitf.dis_ena & ~w_full;
  assign w_retire = oitf.ret_ena & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_alloc)  r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_retire) r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Write and clear never hit the same slot: that needs full or empty, which gates one side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc && (w_wr_idx == PTR_W'(i))) begin
          r_vld[i] <= 1'b1;
        end else if (w_retire && (w_rd_idx == PTR_W'(i))) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_rdwen[w_wr_idx] <= oitf.dis_rdwen;
      r_rdidx[w_wr_idx] <= oitf.dis_rdidx;
      r_pc[w_wr_idx]    <= oitf.dis_pc;
    end
  end

  // A retiring entry still blocks this cycle; x0 writers are never a dependency.
  always_comb begin
    w_dep = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && r_rdwen[i] && (r_rdidx[i] != '0)) begin
        if ((oitf.chk_rs1en && (oitf.chk_rs1idx == r_rdidx[i])) ||
            (oitf.chk_rs2en && (oitf.chk_rs2idx == r_rdidx[i])) ||
            (oitf.chk_rdwen && (oitf.chk_rdidx  == r_rdidx[i]))) begin
          w_dep = 1'b1;
        end
      end
    end
  end

  assign oitf.dis_ptr    = w_wr_idx;
  assign oitf.ret_ptr    = w_rd_idx;
  assign oitf.oitf_full  = w_full;
  assign oitf.oitf_empty = w_empty;
  assign oitf.oitf_dep   = w_dep;
  assign oitf.ret_rdwen  = w_empty ? 1'b0 : r_rdwen[w_rd_idx];
  assign oitf.ret_rdidx  = w_empty ? '0   : r_rdidx[w_rd_idx];
  assign oitf.ret_pc     = w_empty ? '0   : r_pc[w_rd_idx];

endmodule

// File: tb/tb_exu_oitf.sv
// Scoreboard bench for exu_oitf: expected retire payloads are queued at allocate
// and compared against ret_* when the entry retires.
module tb_exu_oitf;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic        rdwen;
    logic [4:0]  rdidx;
    logic [31:0] pc;
  } entry_t;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;
  int   mWr;
  int   mRd;
  entry_t sb[$];
  int   wrapSeq[5] = '{0, 1, 0, 1, 0};

  exu_oitf_if #(.DEPTH(DEPTH)) oitfIf ();

  exu_oitf #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .oitf  (oitfIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic modelDep();
    logic dep;
    dep = 1'b0;
    foreach (sb[i]) begin
      if (sb[i].rdwen && sb[i].rdidx != 5'd0) begin
        if ((oitfIf.chk_rs1en && oitfIf.chk_rs1idx == sb[i].rdidx) ||
            (oitfIf.chk_rs2en && oitfIf.chk_rs2idx == sb[i].rdidx) ||
            (oitfIf.chk_rdwen && oitfIf.chk_rdidx  == sb[i].rdidx))
          dep = 1'b1;
      end
    end
    return dep;
  endfunction

  task automatic clearChk();
    oitfIf.chk_rs1en  = 1'b0;
    oitfIf.chk_rs1idx = '0;
    oitfIf.chk_rs2en  = 1'b0;
    oitfIf.chk_rs2idx = '0;
    oitfIf.chk_rdwen  = 1'b0;
    oitfIf.chk_rdidx  = '0;
  endtask

  // One clock cycle: drive, check pre-edge outputs against the model, clock, update model.
  task automatic applyStimulus(input logic dEna, input logic dRdwen, input logic [4:0] dRdidx,
                               input logic [31:0] dPc, input logic rEna);
    logic   doAlloc;
    logic   doRet;
    entry_t e;
    oitfIf.dis_ena   = dEna;
    oitfIf.dis_rdwen = dRdwen;
    oitfIf.dis_rdidx = dRdidx;
    oitfIf.dis_pc    = dPc;
    oitfIf.ret_ena   = rEna;
    #1;
    checkOutput("empty",   oitfIf.oitf_empty, sb.size() == 0);
    checkOutput("full",    oitfIf.oitf_full,  sb.size() == DEPTH);
    checkOutput("dis_ptr", oitfIf.dis_ptr,    mWr % DEPTH);
    checkOutput("ret_ptr", oitfIf.ret_ptr,    mRd % DEPTH);
    checkOutput("dep",     oitfIf.oitf_dep,   modelDep());
    if (sb.size() == 0) begin
      checkOutput("ret_pc_empty",    oitfIf.ret_pc,    0);
      checkOutput("ret_rdidx_empty", oitfIf.ret_rdidx, 0);
      checkOutput("ret_rdwen_empty", oitfIf.ret_rdwen, 0);
    end
    doAlloc = dEna && (sb.size() < DEPTH);
    doRet   = rEna && (sb.size() > 0);
    if (dEna && !doAlloc)
      $display("[TB] protocol error: dis_ena while full (pc %0h ignored)", dPc);
    if (doRet) begin
      e = sb[0];
      checkOutput("ret_pc",    oitfIf.ret_pc,    e.pc);
      checkOutput("ret_rdidx", oitfIf.ret_rdidx, e.rdidx);
      checkOutput("ret_rdwen", oitfIf.ret_rdwen, e.rdwen);
    end
    @(posedge clk);
    #1;
    if (doRet) begin
      void'(sb.pop_front());
      mRd = (mRd + 1) % (2 * DEPTH);
    end
    if (doAlloc) begin
      sb.push_back('{rdwen: dRdwen, rdidx: dRdidx, pc: dPc});
      mWr = (mWr + 1) % (2 * DEPTH);
    end
    oitfIf.dis_ena = 1'b0;
    oitfIf.ret_ena = 1'b0;
  endtask

  task automatic allocOne(input logic rdwen, input logic [4:0] rd, input logic [31:0] pc);
    applyStimulus(1'b1, rdwen, rd, pc, 1'b0);
  endtask

  task automatic retireOne();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    mWr = 0;
    mRd = 0;
    rst_n = 1'b0;
    oitfIf.dis_ena   = 1'b0;
    oitfIf.dis_rdwen = 1'b0;
    oitfIf.dis_rdidx = '0;
    oitfIf.dis_pc    = '0;
    oitfIf.ret_ena   = 1'b0;
    clearChk();

    #2;
    checkOutput("rst_empty",   oitfIf.oitf_empty, 1);
    checkOutput("rst_full",    oitfIf.oitf_full,  0);
    checkOutput("rst_dep",     oitfIf.oitf_dep,   0);
    checkOutput("rst_dis_ptr", oitfIf.dis_ptr,    0);
    checkOutput("rst_ret_ptr", oitfIf.ret_ptr,    0);
    checkOutput("rst_ret_pc",  oitfIf.ret_pc,     0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill and overflow
    allocOne(1'b1, 5'd5, 32'h8000_0000);
    allocOne(1'b1, 5'd6, 32'h8000_0004);
    checkOutput("fill_full",    oitfIf.oitf_full, 1);
    checkOutput("fill_dis_ptr", oitfIf.dis_ptr,   0);
    allocOne(1'b1, 5'd7, 32'h8000_0008);
    checkOutput("ovf_full",   oitfIf.oitf_full, 1);
    checkOutput("ovf_ret_pc", oitfIf.ret_pc,    32'h8000_0000);
    retireOne();
    checkOutput("ret1_pc", oitfIf.ret_pc, 32'h8000_0004);
    retireOne();
    checkOutput("drain_empty", oitfIf.oitf_empty, 1);

    // RAW hazard and x0 / rdwen=0 filtering
    allocOne(1'b1, 5'd5, 32'h8000_0010);
    oitfIf.chk_rs2en = 1'b1; oitfIf.chk_rs2idx = 5'd5;
    #1 checkOutput("raw_rs2", oitfIf.oitf_dep, 1);
    oitfIf.chk_rs2en = 1'b0; oitfIf.chk_rs1en = 1'b1; oitfIf.chk_rs1idx = 5'd6;
    #1 checkOutput("raw_rs1_miss", oitfIf.oitf_dep, 0);
    clearChk();
    retireOne();
    allocOne(1'b1, 5'd0, 32'h8000_0014);
    oitfIf.chk_rs1en = 1'b1; oitfIf.chk_rs1idx = 5'd0;
    #1 checkOutput("x0_nodep", oitfIf.oitf_dep, 0);
    clearChk();
    retireOne();
    allocOne(1'b0, 5'd9, 32'h8000_0018);
    oitfIf.chk_rdwen = 1'b1; oitfIf.chk_rdidx = 5'd9;
    #1 checkOutput("nordwen_nodep", oitfIf.oitf_dep, 0);
    clearChk();
    retireOne();

    // WAW, held through the retire cycle
    allocOne(1'b1, 5'd10, 32'h8000_001c);
    oitfIf.chk_rdwen = 1'b1; oitfIf.chk_rdidx = 5'd10;
    oitfIf.ret_ena = 1'b1;
    #1 checkOutput("waw_retire_cycle", oitfIf.oitf_dep, 1);
    retireOne();
    checkOutput("waw_after_retire", oitfIf.oitf_dep, 0);
    clearChk();

    // Simultaneous alloc and retire
    allocOne(1'b1, 5'd1, 32'h8000_0100);
    allocOne(1'b1, 5'd2, 32'h8000_0104);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h8000_0108, 1'b1);
    checkOutput("simul_full_full",   oitfIf.oitf_full,  0);
    checkOutput("simul_full_ret_pc", oitfIf.ret_pc,     32'h8000_0104);
    applyStimulus(1'b1, 1'b1, 5'd4, 32'h8000_010c, 1'b1);
    checkOutput("simul_one_ret_pc", oitfIf.ret_pc,    32'h8000_010c);
    checkOutput("simul_one_empty",  oitfIf.oitf_empty, 0);
    checkOutput("simul_one_full",   oitfIf.oitf_full,  0);
    retireOne();
    applyStimulus(1'b1, 1'b1, 5'd8, 32'h8000_0110, 1'b1);
    checkOutput("simul_empty_empty",  oitfIf.oitf_empty, 0);
    checkOutput("simul_empty_ret_pc", oitfIf.ret_pc,     32'h8000_0110);

    // Asynchronous reset between edges with two entries outstanding
    allocOne(1'b1, 5'd12, 32'h8000_0114);
    oitfIf.chk_rs1en = 1'b1; oitfIf.chk_rs1idx = 5'd12;
    #1 checkOutput("pre_rst_dep", oitfIf.oitf_dep, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_empty",  oitfIf.oitf_empty, 1);
    checkOutput("async_rst_full",   oitfIf.oitf_full,  0);
    checkOutput("async_rst_dep",    oitfIf.oitf_dep,   0);
    checkOutput("async_rst_ret_pc", oitfIf.ret_pc,     0);
    sb.delete();
    mWr = 0;
    mRd = 0;
    clearChk();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pointer wrap across five alloc/retire pairs
    for (int k = 0; k < 5; k++) begin
      allocOne(1'b1, 5'(k + 1), 32'h8000_0200 + 32'(4 * k));
      checkOutput("wrap_ret_ptr", oitfIf.ret_ptr, wrapSeq[k]);
      checkOutput("wrap_not_full", oitfIf.oitf_full, 0);
      retireOne();
      checkOutput("wrap_empty", oitfIf.oitf_empty, 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
